// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared types and helpers for the sequential two-layer perceptron
// (nn_mlp_seq) and its MAC unit (nn_mac_unit).
//   - act_t     : hidden-layer activation selector (ReLU / hard-tanh)
//   - state_t   : controller FSM states
//   - W_RST     : power-on / reset weight table (entry k at [k*8 +: 8])
//   - sat_range / sat_signed / sat_relu : saturation helpers on 32-bit
//     signed values, bounds derived from the requested output width
// -----------------------------------------------------------------------------
package nn_pkg;

  typedef enum logic {
    ACT_RELU  = 1'b0,
    ACT_HTANH = 1'b1
  } act_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int NN_DW = 8;
  localparam int NN_NW = 8;

  // L1 = {0x18, 0x12, 0x09, 0x5D}, L2 = {0xEB, 0x2E, 0xEC, 0x30}; entry 0 is the LSB byte.
  localparam logic [NN_NW*NN_DW-1:0] W_RST = {
    8'h30, 8'hEC, 8'h2E, 8'hEB,
    8'h5D, 8'h09, 8'h12, 8'h18
  };

  // Reset value for weight k; indices beyond the table reset to zero.
  function automatic logic signed [NN_DW-1:0] w_rst_entry(input int k);
    logic signed [NN_DW-1:0] v;
    v = '0;
    if (k >= 0 && k < NN_NW) v = W_RST[k*NN_DW +: NN_DW];
    return v;
  endfunction

  function automatic logic signed [31:0] sat_range(input logic signed [31:0] v,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    logic signed [31:0] r;
    r = v;
    if (v > hi) r = hi;
    if (v < lo) r = lo;
    return r;
  endfunction

  // Clamp to the two's-complement range of a w-bit signed value.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return sat_range(v, -hi - 32'sd1, hi);
  endfunction

  // ReLU followed by clamp to the positive range of a w-bit signed value.
  function automatic logic signed [31:0] sat_relu(input logic signed [31:0] v,
                                                  input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return sat_range(v, 32'sd0, hi);
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// -----------------------------------------------------------------------------
// nn_mac_unit
// Signed multiply-accumulate shared by both perceptron layers, with a
// requantise/saturate output stage that looks at acc + current product,
// so the controller can store a neuron result on its last term.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears accumulator)
//   i_clr      : clear accumulator (wins over i_en)
//   i_en       : accumulate i_w * i_x
//   i_w        : signed weight, Q(FRAC)
//   i_x        : signed operand (DW+1 bits so unsigned inputs fit)
//   o_relu     : (acc+prod) >>> FRAC, ReLU, clamp [0, 2^(DW-1)-1]
//   o_htanh    : (acc+prod) >>> FRAC, clamp [-2^FRAC, 2^FRAC]
//   o_sat      : (acc+prod) >>> FRAC, clamp [-2^(DW-1), 2^(DW-1)-1]
// -----------------------------------------------------------------------------
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int DW    = 8,
  parameter int FRAC  = 6,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_w,
  input  logic signed [DW:0]   i_x,
  output logic signed [DW-1:0] o_relu,
  output logic signed [DW-1:0] o_htanh,
  output logic signed [DW-1:0] o_sat
);

  localparam int PW = 2 * DW + 1;

  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [31:0]      w_q;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod  = PW'(i_w) * PW'(i_x);
  assign w_sum   = r_acc + ACC_W'(w_prod);
  // Arithmetic shift floors toward minus infinity, matching the reference model.
  assign w_shift = w_sum >>> FRAC;
  assign w_q     = 32'(w_shift);

  assign o_relu  = DW'(sat_relu(w_q, DW));
  assign o_htanh = DW'(sat_range(w_q, -(32'sd1 <<< FRAC), 32'sd1 <<< FRAC));
  assign o_sat   = DW'(sat_signed(w_q, DW));

  always_ff @(posedge clk) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_sum;
  end

endmodule

// File: rtl/nn_mlp_seq.sv
// -----------------------------------------------------------------------------
// nn_mlp_seq
// Time-multiplexed two-layer perceptron for the PLL loop-gain path. One MAC
// evaluates N_IN*N_HID layer-1 terms then N_HID*N_OUT layer-2 terms, one per
// cycle; result is presented with a valid/ready handshake.
// Optional build macro: NN_HARDTANH_EN adds input act_sel (sampled at input
// acceptance) selecting hard-tanh instead of ReLU for the hidden layer.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input vector handshake
//   in_data              : N_IN unsigned DW-bit inputs, element i at [i*DW +: DW]
//   out_valid/out_ready  : result handshake
//   out_data             : N_OUT signed DW-bit outputs, element o at [o*DW +: DW]
//   w_we/w_addr/w_data   : weight RAM write port (Q(FRAC) signed weights)
//   w_drop               : one-cycle pulse when a write is discarded while busy
//   busy                 : high while layer 1 or layer 2 is being computed
//   act_sel              : (NN_HARDTANH_EN only) 1 = hard-tanh, 0 = ReLU
// Weight layout: L1 (h,i) at h*N_IN+i; L2 (o,h) at N_IN*N_HID + o*N_HID + h.
// Both layers are evaluated in address order, so one pointer walks the RAM.
// -----------------------------------------------------------------------------
module nn_mlp_seq
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_HID = 2,
  parameter int N_OUT = 2,
  parameter int DW    = 8,
  parameter int FRAC  = 6,
  parameter int ACC_W = 20,
  localparam int NW   = N_IN * N_HID + N_HID * N_OUT,
  localparam int AW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*DW-1:0]    in_data,
`ifdef NN_HARDTANH_EN
  input  logic                  act_sel,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*DW-1:0]   out_data,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         w_data,
  output logic                  w_drop,
  output logic                  busy
);

  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;   // terms per neuron, max over layers
  localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int NMAX = (N_HID > N_OUT) ? N_HID : N_OUT; // neurons per layer, max over layers
  localparam int NWD  = (NMAX > 1) ? $clog2(NMAX) : 1;

  if (ACC_W < 2 * DW + $clog2(KMAX) + 1) begin : g_acc_chk
    $error("nn_mlp_seq: ACC_W too narrow, accumulator could wrap");
  end
  if (ACC_W > 32) begin : g_acc_max_chk
    $error("nn_mlp_seq: ACC_W above 32 is not supported by the saturation stage");
  end
  if (FRAC >= DW - 1) begin : g_frac_chk
    $error("nn_mlp_seq: FRAC must leave room for +1.0 in a DW-bit signed value");
  end

  state_t                r_state;
  state_t                w_next;
  act_t                  w_act;

  logic signed [DW-1:0]  r_w   [NW];
  logic [DW-1:0]         r_in  [KMAX];
  logic signed [DW-1:0]  r_hid [KMAX];
  logic signed [DW-1:0]  r_out [N_OUT];
  logic [AW-1:0]         r_wp;
  logic [KW-1:0]         r_k;
  logic [NWD-1:0]        r_neu;
  logic                  r_w_drop;

  logic                  w_accept;
  logic                  w_last_term;
  logic                  w_layer_end;
  logic                  w_addr_ok;
  logic                  w_mac_clr;
  logic signed [DW:0]    w_mac_x;
  logic signed [DW-1:0]  w_relu;
  logic signed [DW-1:0]  w_htanh;
  logic signed [DW-1:0]  w_sat;
  logic signed [DW-1:0]  w_hid_val;

`ifdef NN_HARDTANH_EN
  act_t r_act;
  assign w_act = r_act;
`else
  assign w_act = ACT_RELU;
`endif

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_L1;
      end
      S_L1: begin
        busy = 1'b1;
        if (w_layer_end) w_next = S_L2;
      end
      S_L2: begin
        busy = 1'b1;
        if (w_layer_end) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Term bookkeeping and MAC operand select for the current layer.
  always_comb begin
    w_last_term = 1'b0;
    w_layer_end = 1'b0;
    w_mac_x     = '0;
    if (r_state == S_L1) begin
      w_mac_x     = {1'b0, r_in[r_k]};  // inputs are unsigned: zero-extend
      w_last_term = (r_k == KW'(N_IN - 1));
      w_layer_end = w_last_term && (r_neu == NWD'(N_HID - 1));
    end else if (r_state == S_L2) begin
      w_mac_x     = {r_hid[r_k][DW-1], r_hid[r_k]};  // hidden values are signed
      w_last_term = (r_k == KW'(N_HID - 1));
      w_layer_end = w_last_term && (r_neu == NWD'(N_OUT - 1));
    end
  end

  assign w_accept  = in_valid && in_ready;
  assign w_mac_clr = w_accept || (busy && w_last_term);
  assign w_addr_ok = (32'(w_addr) < NW);
  assign w_hid_val = (w_act == ACT_HTANH) ? w_htanh : w_relu;

  // ---------------------------------------------------------------------------
  // MAC
  // ---------------------------------------------------------------------------
  nn_mac_unit #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_mac_clr),
    .i_en    (busy),
    .i_w     (r_w[r_wp]),
    .i_x     (w_mac_x),
    .o_relu  (w_relu),
    .o_htanh (w_htanh),
    .o_sat   (w_sat)
  );

  // ---------------------------------------------------------------------------
  // Weight RAM: writable only while not computing, so a running evaluation
  // always sees one consistent weight set. A write in the accepting cycle
  // commits before the first term is read.
  // ---------------------------------------------------------------------------
  // NOTE: this memory is deliberately reset because the reset must reload the
  // default weight table; plain storage arrays normally get no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) r_w[k] <= DW'(w_rst_entry(k));
    end else if (w_we && w_addr_ok && !busy) begin
      r_w[w_addr] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < KMAX; i++) begin
        r_in[i]  <= '0;
        r_hid[i] <= '0;
      end
      for (int o = 0; o < N_OUT; o++) r_out[o] <= '0;
      r_wp     <= '0;
      r_k      <= '0;
      r_neu    <= '0;
      r_w_drop <= 1'b0;
`ifdef NN_HARDTANH_EN
      r_act    <= ACT_RELU;
`endif
    end else begin
      r_w_drop <= w_we && w_addr_ok && busy;
      if (w_accept) begin
        for (int i = 0; i < N_IN; i++) r_in[i] <= in_data[i*DW +: DW];
        r_wp  <= '0;
        r_k   <= '0;
        r_neu <= '0;
`ifdef NN_HARDTANH_EN
        r_act <= act_sel ? ACT_HTANH : ACT_RELU;
`endif
      end else if (busy) begin
        r_wp <= r_wp + AW'(1);
        if (w_last_term) begin
          r_k   <= '0;
          r_neu <= w_layer_end ? '0 : r_neu + NWD'(1);
          if (r_state == S_L1) r_hid[r_neu] <= w_hid_val;
          else                 r_out[r_neu] <= w_sat;
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < N_OUT; o++) out_data[o*DW +: DW] = r_out[o];
  end

  assign w_drop = r_w_drop;

endmodule

// File: tb/tb_nn_mlp_seq.sv
// -----------------------------------------------------------------------------
// tb_nn_mlp_seq
// Directed bench for nn_mlp_seq with default parameters (2-2-2, DW=8, FRAC=6).
// Expected outputs are hand-computed from the default weight table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nn_mlp_seq;

  localparam int DW  = 8;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        w_we = 1'b0;
  logic [2:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        w_drop;
  logic        busy;
`ifdef NN_HARDTANH_EN
  logic        act_sel = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nn_mlp_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef NN_HARDTANH_EN
    .act_sel   (act_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_drop    (w_drop),
    .busy      (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only; comparisons live in the test tasks)
  // ---------------------------------------------------------------------------
  task automatic reset_dut();
    rst_n = 1'b0;
    in_valid = 1'b0;
    w_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_weight(input logic [2:0] a, input logic [7:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents a vector and returns #1 after the accepting edge.
  task automatic start_vector(input logic [15:0] d, output bit ok);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = (in_ready === 1'b1);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles until out_valid (bounded to 50) and captures out_data.
  task automatic wait_result(output logic [15:0] got, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    got = out_data;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_dut();
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (w_drop !== 1'b0)    begin n_bad++; $display("FAIL reset_w_drop: got %b want 0", w_drop); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [15:0] got; int lat; bit ok;
    start_vector({8'd64, 8'd64}, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_accept: in_ready never rose"); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_result(got, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    // o0 = 59 (0x3B), o1 = 63 (0x3F)
    n_cmp++; if (got !== 16'h3F3B) begin n_bad++; $display("FAIL basic_out: got %h want 3f3b", got); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_done_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_out_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_back_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_hidden_sat();
    logic [15:0] got; int lat; bit ok;
    start_vector({8'd255, 8'd255}, ok);
    wait_result(got, lat);
    // hidden both clamp to 127: o0 = 25*127>>6 = 49, o1 = 28*127>>6 = 55
    n_cmp++; if (got !== 16'h3731) begin n_bad++; $display("FAIL hidden_sat_out: got %h want 3731", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_relu_and_out_sat();
    logic [15:0] got; int lat; bit ok;
    write_weight(3'd0, 8'hE0);
    write_weight(3'd1, 8'hE0);
    n_cmp++; if (w_drop !== 1'b0) begin n_bad++; $display("FAIL idle_write_no_drop: got %b want 0", w_drop); end
    start_vector({8'd128, 8'd128}, ok);
    wait_result(got, lat);
    // h0 = -64*128>>6 < 0 -> 0; h1 = 127; o0 = 46*127>>6 = 91, o1 = 48*127>>6 = 95
    n_cmp++; if (got !== 16'h5F5B) begin n_bad++; $display("FAIL relu_out: got %h want 5f5b", got); end
    @(posedge clk); #1;
    for (int a = 4; a < 8; a++) write_weight(3'(a), 8'h7F);
    start_vector({8'd255, 8'd255}, ok);
    wait_result(got, lat);
    // o = 127*127>>6 = 252 -> saturates to 127 on both outputs
    n_cmp++; if (got !== 16'h7F7F) begin n_bad++; $display("FAIL out_sat: got %h want 7f7f", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] got; int lat; bit ok;
    reset_dut();
    out_ready = 1'b0;
    start_vector({8'd64, 8'd64}, ok);
    wait_result(got, lat);
    n_cmp++; if (got !== 16'h3F3B) begin n_bad++; $display("FAIL bp_first_out: got %h want 3f3b", got); end
    in_valid = 1'b1; in_data = {8'd128, 8'd128};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_data !== 16'h3F3B) begin n_bad++; $display("FAIL bp_hold_data c%0d: got %h want 3f3b", c, out_data); end
      n_cmp++; if (out_valid !== 1'b1)    begin n_bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid); end
      n_cmp++; if (in_ready !== 1'b0)     begin n_bad++; $display("FAIL bp_hold_in_ready c%0d: got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_release_idle: got %b want 1", in_ready); end
    start_vector({8'd255, 8'd255}, ok);
    wait_result(got, lat);
    n_cmp++; if (got !== 16'h3731) begin n_bad++; $display("FAIL bp_next_out: got %h want 3731", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_during_busy();
    logic [15:0] got; int lat; bit ok;
    start_vector({8'd64, 8'd64}, ok);
    // in L1 now: this write must be discarded and flagged
    w_we = 1'b1; w_addr = 3'd0; w_data = 8'h7F;
    @(posedge clk); #1;
    w_we = 1'b0;
    n_cmp++; if (w_drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: got %b want 1", w_drop); end
    @(posedge clk); #1;
    n_cmp++; if (w_drop !== 1'b0) begin n_bad++; $display("FAIL drop_pulse_end: got %b want 0", w_drop); end
    wait_result(got, lat);
    n_cmp++; if (got !== 16'h3F3B) begin n_bad++; $display("FAIL drop_same_run: got %h want 3f3b", got); end
    @(posedge clk); #1;
    start_vector({8'd64, 8'd64}, ok);
    wait_result(got, lat);
    // a committed 0x7F at addr0 would give o0 = 31; weight must be unchanged
    n_cmp++; if (got !== 16'h3F3B) begin n_bad++; $display("FAIL drop_next_run: got %h want 3f3b", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [15:0] got; int lat; bit ok;
    write_weight(3'd1, 8'h00);
    start_vector({8'd255, 8'd255}, ok);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_in_l2_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_no_output c%0d: got %b want 0", c, out_valid); end
    end
    start_vector({8'd64, 8'd64}, ok);
    wait_result(got, lat);
    // reloaded W_RST gives {59, 63}; the stale addr1=0 would give o0 = 65
    n_cmp++; if (got !== 16'h3F3B) begin n_bad++; $display("FAIL abort_reload: got %h want 3f3b", got); end
    @(posedge clk); #1;
  endtask

`ifdef NN_HARDTANH_EN
  task automatic test_hardtanh();
    logic [15:0] got; int lat; bit ok;
    reset_dut();
    for (int a = 0; a < 4; a++) write_weight(3'(a), 8'h7F);
    act_sel = 1'b1;
    start_vector({8'd255, 8'd255}, ok);
    act_sel = 1'b0;
    wait_result(got, lat);
    // hidden clamp to 64: o0 = 25*64>>6 = 25, o1 = 28*64>>6 = 28
    n_cmp++; if (got !== 16'h1C19) begin n_bad++; $display("FAIL htanh_out: got %h want 1c19", got); end
    @(posedge clk); #1;
    start_vector({8'd255, 8'd255}, ok);
    wait_result(got, lat);
    // ReLU path clamps hidden to 127: {49, 55}
    n_cmp++; if (got !== 16'h3731) begin n_bad++; $display("FAIL htanh_relu_sel: got %h want 3731", got); end
    @(posedge clk); #1;
    reset_dut();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hidden_sat();
    test_relu_and_out_sat();
    test_backpressure();
    test_write_during_busy();
    test_reset_abort();
`ifdef NN_HARDTANH_EN
    test_hardtanh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
